// File: rtl/am_audio_pwm.sv
// AM audio back end: leaky DC removal on the envelope, then a period-aligned 1-bit PWM.
// Sample to duty_pending takes 2 cycles; no backpressure, and a pending duty that is not yet applied is overwritten (pulse on sample_dropped).
module am_audio_pwm #(
  parameter int DATA_WIDTH = 12,
  parameter int PWM_WIDTH  = 10,
  parameter int DC_SHIFT   = 8,
  parameter int SETTLE_LOG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] amdemod_in,
  input  logic                  sample_valid,
  output logic                  pwm_out,
  output logic [PWM_WIDTH-1:0]  duty_out,
  output logic                  running,
  output logic                  sample_dropped
);

  localparam int AW = DATA_WIDTH + DC_SHIFT;
  localparam int SH = DATA_WIDTH + 1 - PWM_WIDTH;
  localparam logic [PWM_WIDTH-1:0] MID     = {1'b1, {(PWM_WIDTH-1){1'b0}}};
  localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {PRIME, SETTLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [SETTLE_LOG-1:0]   settle_q, settle_d;
  logic [AW-1:0]           dc_acc_q, dc_acc_d;
  logic [DATA_WIDTH-1:0]   x_q;
  logic                    xv_q;
  logic [PWM_WIDTH-1:0]    cnt_q;
  logic [PWM_WIDTH-1:0]    pending_q;
  logic [PWM_WIDTH-1:0]    active_q;
  logic                    flag_q;
  logic                    pwm_q;
  logic                    drop_q;

  logic [DATA_WIDTH-1:0]   dc_old;
  logic signed [DATA_WIDTH:0] ac;
  logic [PWM_WIDTH-1:0]    duty_calc;
  logic [AW-1:0]           dc_leak;
  logic                    pend_wr;
  logic [PWM_WIDTH-1:0]    pend_val;
  logic                    wrap;

  assign dc_old    = dc_acc_q[AW-1:DC_SHIFT];
  assign ac        = $signed({1'b0, x_q}) - $signed({1'b0, dc_old});
  assign duty_calc = PWM_WIDTH'(ac >>> SH) + MID;
  // Final value always fits in AW bits, so modulo arithmetic is exact.
  assign dc_leak   = dc_acc_q + AW'(x_q) - AW'(dc_old);
  assign wrap      = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PRIME;
      settle_q <= '0;
      dc_acc_q <= '0;
      x_q      <= '0;
      xv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      dc_acc_q <= dc_acc_d;
      xv_q     <= sample_valid;
      if (sample_valid) x_q <= amdemod_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   if (xv_q) state_d = SETTLE;
      SETTLE:  if (xv_q && settle_q == '1) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    dc_acc_d = dc_acc_q;
    settle_d = settle_q;
    pend_wr  = 1'b0;
    pend_val = MID;
    if (xv_q) begin
      case (state_q)
        PRIME: begin
          dc_acc_d = {x_q, {DC_SHIFT{1'b0}}};
          settle_d = '0;
        end
        SETTLE: begin
          dc_acc_d = dc_leak;
          settle_d = settle_q + 1'b1;
          pend_wr  = 1'b1;
        end
        default: begin
          dc_acc_d = dc_leak;
          pend_wr  = 1'b1;
          pend_val = duty_calc;
        end
      endcase
    end
  end

  assign running = (state_q == RUN);

  // Duty only moves at the period boundary so a period never changes width mid-way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= MID;
      active_q  <= MID;
      flag_q    <= 1'b0;
      pwm_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      pwm_q  <= (cnt_q < active_q);
      drop_q <= pend_wr & flag_q & ~wrap;
      if (wrap) active_q <= pending_q;
      if (pend_wr) begin
        pending_q <= pend_val;
        flag_q    <= 1'b1;
      end else if (wrap) begin
        flag_q <= 1'b0;
      end
    end
  end

  assign pwm_out        = pwm_q;
  assign duty_out       = active_q;
  assign sample_dropped = drop_q;

endmodule

// File: doc/am_audio_pwm.md
AM_AUDIO_PWM -- requirements
Module: am_audio_pwm

Downstream of the AM demodulator: removes DC from the 12-bit envelope and drives a 1-bit PWM audio output.

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, giving the width of the envelope input.
REQ-002 SHALL have parameter PWM_WIDTH, default 10, giving the PWM period bits; PWM_WIDTH <= DATA_WIDTH+1.
REQ-003 SHALL have parameter DC_SHIFT, default 8, giving the DC-estimator leak shift (time constant of 2^DC_SHIFT samples).
REQ-004 SHALL have parameter SETTLE_LOG, default 4; the settle phase lasts 2^SETTLE_LOG samples.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 amdemod_in  input  DATA_WIDTH  unsigned envelope sample.
REQ-008 sample_valid  input  1  one-cycle strobe qualifying amdemod_in.
REQ-009 pwm_out  output  1  registered PWM audio bit.
REQ-010 duty_out  output  PWM_WIDTH  duty currently applied (duty_active).
REQ-011 running  output  1  high only in state RUN.
REQ-012 sample_dropped  output  1  one-cycle pulse when a pending duty is overwritten before use.

Function
REQ-013 SHALL hold dc_acc (DATA_WIDTH+DC_SHIFT bits, unsigned); dc = dc_acc >> DC_SHIFT.
REQ-014 On each accepted sample x in states SETTLE and RUN, SHALL compute dc_acc <= dc_acc + x - (dc_acc >> DC_SHIFT).
REQ-015 ac SHALL equal x - dc_old, computed as signed DATA_WIDTH+1 bits, where dc_old is dc before this sample's update.
REQ-016 duty SHALL equal (ac >>> (DATA_WIDTH+1-PWM_WIDTH)) + 2^(PWM_WIDTH-1), taken as PWM_WIDTH unsigned; arithmetic shift floors toward minus infinity; no saturation is needed.
REQ-017 Pipeline: a sample strobed at edge t is registered at t; duty_pending is written at edge t+1 (2-cycle latency to pending).
REQ-018 FSM states: PRIME, SETTLE, RUN; reset state is PRIME.
REQ-019 PRIME: the first sample loads dc_acc <= x << DC_SHIFT (no leak update); go to SETTLE with settle count 0.
REQ-020 SETTLE: each sample updates dc_acc and increments the settle count; duty_pending is written as midscale 2^(PWM_WIDTH-1).
REQ-021 SETTLE -> RUN on the 2^SETTLE_LOG-th sample; that sample still writes midscale.
REQ-022 RUN: each sample writes the duty computed per REQ-016; RUN is left only by reset.
REQ-023 SHALL keep a free-running period counter cnt from 0 to 2^PWM_WIDTH-1, wrapping to 0.
REQ-024 pwm_out SHALL be registered as (cnt < duty_active); duty 0 gives constant low; duty 2^PWM_WIDTH-1 gives low for one cycle per period.
REQ-025 duty_active <= duty_pending only at the edge where cnt = 2^PWM_WIDTH-1 (glitch-free, period-aligned); a pending flag is cleared on transfer.
REQ-026 A pending write while the pending flag is set SHALL overwrite pending (last wins) and pulse sample_dropped for one cycle.
REQ-027 A pending write on the same edge as a transfer SHALL transfer the old pending value, store the new one with the flag set, and not assert sample_dropped.
REQ-028 sample_valid SHALL be ignored on the clk edge where rst is deasserting only if rst is still sampled high.

Reset
REQ-029 rst high SHALL immediately force the following, regardless of clk:
  - cnt = 0, dc_acc = 0
  - duty_pending = duty_active = 2^(PWM_WIDTH-1), pending flag clear
  - state PRIME, settle count 0
  - pwm_out = 0, running = 0, sample_dropped = 0
  - pipeline registers cleared
REQ-030 Reset mid-period or mid-SETTLE SHALL discard all history; the next sample is treated as a PRIME sample.

Verification (defaults: DATA_WIDTH 12, PWM_WIDTH 10, DC_SHIFT 8, SETTLE_LOG 4)
REQ-031 Reset asserted at cnt=600 in RUN -> same cycle: pwm_out 0, duty_out 512, running 0; after release, cnt restarts at 0.
REQ-032 17 samples of 2000 -> dc_acc primed to 512000; running rises after the 17th sample; pwm_out is high for 512 of each 1024 cycles.
REQ-033 Running at DC 2000, then one sample of 2800 -> ac=800, duty_pending=612; duty_out becomes 612 only after the next cnt=1023 edge.
REQ-034 Primed and settled on 0, then 4095 -> duty 1023; the following sample of 0 (dc=15) -> ac=-15, duty 510.
REQ-035 Two RUN samples within one PWM period -> second duty is applied, sample_dropped pulses exactly once; a sample on the wrap edge -> no pulse.
REQ-036 Sample at cnt=300 -> duty_out stays unchanged through cnt=1023, then updates; pwm_out shows no mid-period width change.
